slice_mux: RTL and testbench

- Encoder-side slice multiplexer. Takes one 256-bit chunk word stream per slice and emits a single byte-packed 256-bit stream.
- Chunks are interleaved round-robin: slice 0, 1, …, slices_per_line-1, then the next chunk row. Chunk boundaries are not word-aligned.
- Sits between the per-slice rate buffers and the bitstream output. It produces exactly the layout that slice_demux in the decoder splits apart.

---
 rtl/vdcm_pkg.sv | 22 ++
 rtl/slice_mux_byte_packer.sv | 58 +++++
 rtl/slice_mux.sv | 222 ++++++++++++++++++++++
 tb/tb_slice_mux.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdcm_pkg.sv
// Shared types and helpers for the slice mux/demux codec datapath.
// Word geometry, FSM states and chunk sizing.
package vdcm_pkg;

  localparam int BYTES_PER_WORD = 32;
  localparam int WORD_W         = 256;
  localparam int PPS_WORDS      = 4;

  typedef enum logic [1:0] {
    IDLE,
    PPS,
    RUN,
    FLUSH
  } state_e;

  function automatic logic [11:0] ceil_words(input logic [15:0] bytes);
    logic [16:0] s;
    s = {1'b0, bytes} + 17'd31;
    return s[16:5];
  endfunction

endpackage

// File: rtl/slice_mux_byte_packer.sv
// Residual register and append/emit datapath for the slice mux.
// Bytes above fill are kept zero so the residual doubles as the padded tail.
module byte_packer
  import vdcm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic [5:0]        push_k,
  output logic              emit,
  output logic [WORD_W-1:0] emit_data,
  output logic [4:0]        fill,
  output logic [WORD_W-1:0] residual
);

  logic [WORD_W-1:0]   res_q, res_d;
  logic [4:0]          fill_q, fill_d;
  logic [WORD_W-1:0]   mask;
  logic [2*WORD_W-1:0] merged;
  logic [5:0]          sum;

  always_comb begin
    mask = push_k[5] ? {WORD_W{1'b1}}
                     : ~({WORD_W{1'b1}} << {push_k[4:0], 3'b000});
    merged = {{WORD_W{1'b0}}, res_q}
           | ({{WORD_W{1'b0}}, push_data & mask} << {fill_q, 3'b000});
    sum = {1'b0, fill_q} + push_k;
    emit = push & sum[5] & ~clear;
    emit_data = merged[WORD_W-1:0];
    res_d = res_q;
    fill_d = fill_q;
    if (clear) begin
      res_d = '0;
      fill_d = '0;
    end else if (push) begin
      // leftover of an overflow shifts down to byte 0
      res_d = sum[5] ? merged[2*WORD_W-1:WORD_W]
                     : merged[WORD_W-1:0];
      fill_d = sum[4:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      fill_q <= '0;
    end else begin
      res_q <= res_d;
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;
  assign residual = res_q;

endmodule

// File: rtl/slice_mux.sv
// Encoder slice multiplexer: round-robin chunk interleave into a byte-packed stream.
// Optional PPS header forwarding enabled by SLICE_MUX_PPS_EN.
module slice_mux
  import vdcm_pkg::*;
#(
  parameter int MAX_NBR_SLICES  = 2,
  parameter int MAX_SLICE_WIDTH = 2560
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [9:0]                       slices_per_line,
  input  logic [15:0]                      chunk_size,
  input  logic                             in_sof,
  input  logic                             in_eof,
  input  logic [WORD_W*MAX_NBR_SLICES-1:0] in_data_p,
  input  logic [MAX_NBR_SLICES-1:0]        in_valid,
  output logic [MAX_NBR_SLICES-1:0]        in_ready,
`ifdef SLICE_MUX_PPS_EN
  input  logic [WORD_W-1:0]                pps_data,
  input  logic                             pps_valid,
  output logic                             pps_ready,
  output logic                             out_is_pps,
`endif
  output logic [WORD_W-1:0]                out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             out_done
);

  localparam int SW = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;

  if (MAX_NBR_SLICES < 1 || MAX_SLICE_WIDTH < 1) begin : g_bad_cfg
    $error("slice_mux: illegal parameter configuration");
  end

  state_e            state_q, state_d;
  logic [SW-1:0]     active_q, active_d;
  logic [11:0]       word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              out_done_q, out_done_d;

  logic              can_out, rdy_ok, hs, last_word, res_emit, pk_clear;
  logic [WORD_W-1:0] sel_data;
  logic [11:0]       wpc;
  logic [4:0]        rem;
  logic [5:0]        k;
  logic              pk_emit;
  logic [WORD_W-1:0] pk_data, pk_res;
  logic [4:0]        pk_fill;

`ifdef SLICE_MUX_PPS_EN
  logic [1:0] pps_cnt_q, pps_cnt_d;
  logic       is_pps_q, is_pps_d;
  logic       pps_hs;
`endif

  always_comb begin
    can_out = ~out_valid_q | out_ready;
    rdy_ok = (state_q == RUN) & can_out & ~in_sof & ~flush;
    in_ready = '0;
    sel_data = '0;
    for (int s = 0; s < MAX_NBR_SLICES; s++) begin
      if (SW'(s) == active_q) begin
        in_ready[s] = rdy_ok;
        sel_data = in_data_p[s*WORD_W +: WORD_W];
      end
    end
    hs = |(in_valid & in_ready);
    wpc = ceil_words(chunk_size);
    rem = chunk_size[4:0];
    last_word = (word_cnt_q == wpc - 12'd1);
    k = (last_word && rem != 5'd0) ? {1'b0, rem} : 6'd32;
  end

  assign pk_clear = in_sof | flush | res_emit;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .push      (hs),
    .push_data (sel_data),
    .push_k    (k),
    .emit      (pk_emit),
    .emit_data (pk_data),
    .fill      (pk_fill),
    .residual  (pk_res)
  );

  always_comb begin
    state_d = state_q;
    active_d = active_q;
    word_cnt_d = word_cnt_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_last_d = out_last_q & ~out_ready;
    out_done_d = 1'b0;
    res_emit = 1'b0;
`ifdef SLICE_MUX_PPS_EN
    pps_cnt_d = pps_cnt_q;
    is_pps_d = is_pps_q & ~out_ready;
    pps_ready = (state_q == PPS) & can_out & ~in_sof & ~flush;
    pps_hs = pps_valid & pps_ready;
`endif
    if (pk_emit) begin
      out_data_d = pk_data;
      out_valid_d = 1'b1;
      out_last_d = 1'b0;
`ifdef SLICE_MUX_PPS_EN
      is_pps_d = 1'b0;
`endif
    end
    if (hs) begin
      if (last_word) begin
        word_cnt_d = '0;
        active_d = (10'(active_q) + 10'd1 == slices_per_line)
                 ? '0 : active_q + SW'(1);
      end else begin
        word_cnt_d = word_cnt_q + 12'd1;
      end
    end
    unique case (state_q)
      IDLE: ;
      PPS: begin
`ifdef SLICE_MUX_PPS_EN
        if (pps_hs) begin
          out_data_d = pps_data;
          out_valid_d = 1'b1;
          out_last_d = 1'b0;
          is_pps_d = 1'b1;
          pps_cnt_d = pps_cnt_q + 2'd1;
          if (pps_cnt_q == 2'(PPS_WORDS - 1)) begin
            pps_cnt_d = '0;
            state_d = RUN;
          end
        end
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        if (in_eof) state_d = FLUSH;
      end
      FLUSH: begin
        // out_last marks that the padded tail is already registered
        if (out_last_q) begin
          if (out_ready) begin
            state_d = IDLE;
            out_done_d = 1'b1;
          end
        end else if (pk_fill == 5'd0) begin
          state_d = IDLE;
          out_done_d = 1'b1;
        end else if (can_out) begin
          res_emit = 1'b1;
          out_data_d = pk_res;
          out_valid_d = 1'b1;
          out_last_d = 1'b1;
`ifdef SLICE_MUX_PPS_EN
          is_pps_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_sof | flush) begin
`ifdef SLICE_MUX_PPS_EN
      state_d = flush ? IDLE : PPS;
      pps_cnt_d = '0;
      is_pps_d = 1'b0;
`else
      state_d = flush ? IDLE : RUN;
`endif
      active_d = '0;
      word_cnt_d = '0;
      out_valid_d = 1'b0;
      out_last_d = 1'b0;
      out_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      active_q <= '0;
      word_cnt_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_done_q <= 1'b0;
`ifdef SLICE_MUX_PPS_EN
      pps_cnt_q <= '0;
      is_pps_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      active_q <= active_d;
      word_cnt_q <= word_cnt_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      out_done_q <= out_done_d;
`ifdef SLICE_MUX_PPS_EN
      pps_cnt_q <= pps_cnt_d;
      is_pps_q <= is_pps_d;
`endif
    end
  end

  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last = out_last_q;
  assign out_done = out_done_q;
`ifdef SLICE_MUX_PPS_EN
  assign out_is_pps = is_pps_q;
`endif

endmodule

// File: tb/tb_slice_mux.sv
// Directed bench for slice_mux (default build, two slice ports).
// Expected streams are built from the chunk byte pattern of each scenario.
module tb_slice_mux;

  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [9:0]    slices_per_line = 10'd2;
  logic [15:0]   chunk_size = 16'd64;
  logic          in_sof = 1'b0;
  logic          in_eof = 1'b0;
  logic [256*NS-1:0] in_data_p = '0;
  logic [NS-1:0] in_valid = '0;
  logic [NS-1:0] in_ready;
  logic [255:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          out_done;

  slice_mux #(
    .MAX_NBR_SLICES  (NS),
    .MAX_SLICE_WIDTH (2560)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .slices_per_line (slices_per_line),
    .chunk_size      (chunk_size),
    .in_sof          (in_sof),
    .in_eof          (in_eof),
    .in_data_p       (in_data_p),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .out_done        (out_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [255:0] src0[$], src1[$], exp_w[$], got_w[$];
  logic         exp_l[$], got_l[$];
  int           got_c[$], in_c[$];
  int           p0, p1, cyc, done_cnt, done_c, cur_spl;
  bit           tmo;
  logic [NS-1:0] rdy_s;
  logic         ov_s;
  logic [255:0] od_s;

  function automatic logic [7:0] bval(int s, int r, int i);
    return 8'(s * 97 + r * 41 + i + 1);
  endfunction

  task automatic load_frame(input int spl, input int cs, input int rows,
                            input int salt);
    logic [7:0]   b[$];
    logic [255:0] w;
    int           wpc, n;
    src0.delete(); src1.delete(); exp_w.delete(); exp_l.delete();
    got_w.delete(); got_l.delete(); got_c.delete(); in_c.delete();
    p0 = 0; p1 = 0; done_cnt = 0; done_c = -1; tmo = 0;
    cur_spl = spl;
    slices_per_line = 10'(spl);
    chunk_size = 16'(cs);
    wpc = (cs + 31) / 32;
    for (int r = 0; r < rows; r++)
      for (int s = 0; s < 2; s++)
        for (int wi = 0; wi < wpc; wi++) begin
          w = '0;
          for (int i = 0; i < 32; i++)
            w[8*i +: 8] = (wi*32 + i < cs) ? bval(s + salt, r, wi*32 + i)
                                           : 8'hEE;
          if (s == 0) src0.push_back(w);
          else src1.push_back(w);
        end
    for (int r = 0; r < rows; r++)
      for (int s = 0; s < spl; s++)
        for (int i = 0; i < cs; i++) b.push_back(bval(s + salt, r, i));
    for (int j = 0; j < b.size(); j += 32) begin
      w = '0;
      n = 0;
      for (int i = 0; i < 32; i++)
        if (j + i < b.size()) begin
          w[8*i +: 8] = b[j + i];
          n++;
        end
      exp_w.push_back(w);
      exp_l.push_back(n < 32);
    end
  endtask

  task automatic step();
    in_valid[0] = p0 < src0.size();
    in_valid[1] = p1 < src1.size();
    in_data_p = '0;
    if (in_valid[0]) in_data_p[255:0] = src0[p0];
    if (in_valid[1]) in_data_p[511:256] = src1[p1];
    #1;
    rdy_s = in_ready;
    ov_s = out_valid;
    od_s = out_data;
    if (in_valid[0] && in_ready[0]) begin p0++; in_c.push_back(cyc); end
    if (in_valid[1] && in_ready[1]) begin p1++; in_c.push_back(cyc); end
    if (out_valid && out_ready) begin
      got_w.push_back(out_data);
      got_l.push_back(out_last);
      got_c.push_back(cyc);
    end
    if (out_done) begin done_cnt++; done_c = cyc; end
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_frame();
    in_sof = 1'b1;
    step();
    in_sof = 1'b0;
  endtask

  task automatic feed();
    int n;
    n = 0;
    while (n < 2000 && (p0 < src0.size() || (cur_spl > 1 && p1 < src1.size()))) begin
      step();
      n++;
    end
    if (n >= 2000) tmo = 1;
  endtask

  task automatic finish_frame();
    int n;
    in_eof = 1'b1;
    step();
    in_eof = 1'b0;
    n = 0;
    while (n < 100 && done_cnt == 0) begin step(); n++; end
    if (done_cnt == 0) tmo = 1;
    step();
    step();
  endtask

  task automatic test_reset();
    in_valid = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b l=%b d=%b expected 0 0 0",
               out_valid, out_last, out_done);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    checks++;
    if (in_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 00", in_ready);
    end
    rst_n = 1'b1;
    load_frame(2, 64, 1, 0);
    step();
    checks++;
    if (rdy_s !== 2'b00) begin
      errors++;
      $display("FAIL idle_in_ready: got %b expected 00", rdy_s);
    end
  endtask

  task automatic test_aligned();
    load_frame(2, 64, 2, 0);
    out_ready = 1'b1;
    start_frame();
    feed();
    finish_frame();
    checks++;
    if (tmo || got_w.size() != exp_w.size()) begin
      errors++;
      $display("FAIL aligned_count: got %0d words (timeout %0d) expected %0d",
               got_w.size(), tmo, exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== 1'b0) begin
        errors++;
        $display("FAIL aligned_word[%0d]: got %h last %b expected %h last 0",
                 i, got_w[i], got_l[i], exp_w[i]);
      end
    end
    for (int i = 0; i < in_c.size() && i < got_c.size(); i++) begin
      checks++;
      if (got_c[i] !== in_c[i] + 1) begin
        errors++;
        $display("FAIL aligned_latency[%0d]: got cycle %0d expected %0d",
                 i, got_c[i], in_c[i] + 1);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL aligned_done: got %0d pulses expected 1", done_cnt);
    end
  endtask

  task automatic test_unaligned();
    load_frame(2, 40, 2, 3);
    out_ready = 1'b1;
    start_frame();
    feed();
    finish_frame();
    checks++;
    if (tmo || got_w.size() != 5) begin
      errors++;
      $display("FAIL unaligned_count: got %0d words (timeout %0d) expected 5",
               got_w.size(), tmo);
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL unaligned_word[%0d]: got %h last %b expected %h last %b",
                 i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      end
    end
    if (got_w.size() > 1) begin
      checks++;
      if (got_w[1][7:0] !== bval(3, 0, 32) || got_w[1][71:64] !== bval(4, 0, 0)) begin
        errors++;
        $display("FAIL unaligned_seam: got %h/%h expected %h/%h",
                 got_w[1][7:0], got_w[1][71:64], bval(3, 0, 32), bval(4, 0, 0));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] snap;
    int n;
    load_frame(2, 40, 1, 5);
    out_ready = 1'b0;
    ov_s = 1'b0;
    start_frame();
    n = 0;
    while (!ov_s && n < 50) begin step(); n++; end
    snap = od_s;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (ov_s !== 1'b1 || od_s !== snap || rdy_s !== 2'b00) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%b rdy=%b data %h expected v=1 rdy=00 data %h",
                 c, ov_s, rdy_s, od_s, snap);
      end
    end
    out_ready = 1'b1;
    feed();
    finish_frame();
    checks++;
    if (tmo || got_w.size() != 3 || p0 != 2 || p1 != 2) begin
      errors++;
      $display("FAIL stall_count: got %0d words p0=%0d p1=%0d expected 3 2 2",
               got_w.size(), p0, p1);
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL stall_word[%0d]: got %h last %b expected %h last %b",
                 i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_flush_residual();
    load_frame(1, 48, 1, 7);
    out_ready = 1'b1;
    start_frame();
    feed();
    finish_frame();
    checks++;
    if (tmo || got_w.size() != 2) begin
      errors++;
      $display("FAIL resid_count: got %0d words expected 2", got_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL resid_word[%0d]: got %h last %b expected %h last %b",
                 i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      end
    end
    if (got_w.size() == 2) begin
      checks++;
      if (got_l[1] !== 1'b1 || got_w[1][255:128] !== '0 || done_c <= got_c[1]) begin
        errors++;
        $display("FAIL resid_tail: got last %b hi %h done cyc %0d expected 1 0 after %0d",
                 got_l[1], got_w[1][255:128], done_c, got_c[1]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL resid_done: got %0d pulses expected 1", done_cnt);
    end
  endtask

  task automatic test_flush_empty();
    load_frame(1, 32, 2, 9);
    out_ready = 1'b1;
    start_frame();
    feed();
    finish_frame();
    checks++;
    if (tmo || got_w.size() != 2 || done_cnt !== 1) begin
      errors++;
      $display("FAIL empty_flush: got %0d words %0d done expected 2 words 1 done",
               got_w.size(), done_cnt);
    end
    for (int i = 0; i < got_l.size(); i++) begin
      checks++;
      if (got_l[i] !== 1'b0 || got_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL empty_word[%0d]: got %h last %b expected %h last 0",
                 i, got_w[i], got_l[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_restart();
    int n;
    load_frame(2, 64, 1, 11);
    out_ready = 1'b1;
    start_frame();
    n = 0;
    while (p0 < 1 && n < 20) begin step(); n++; end
    in_sof = 1'b1;
    step();
    in_sof = 1'b0;
    checks++;
    if (rdy_s !== 2'b00 || p0 != 1) begin
      errors++;
      $display("FAIL restart_drop: got rdy=%b p0=%0d expected 00 1", rdy_s, p0);
    end
    load_frame(2, 64, 1, 13);
    step();
    checks++;
    if (ov_s !== 1'b0) begin
      errors++;
      $display("FAIL restart_valid: got %b expected 0", ov_s);
    end
    feed();
    finish_frame();
    checks++;
    if (tmo || got_w.size() != exp_w.size()) begin
      errors++;
      $display("FAIL restart_count: got %0d words expected %0d",
               got_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL restart_word[%0d]: got %h expected %h",
                 i, got_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_single_slice();
    load_frame(1, 33, 3, 17);
    out_ready = 1'b1;
    start_frame();
    feed();
    finish_frame();
    checks++;
    if (tmo || got_w.size() != 4 || p1 != 0) begin
      errors++;
      $display("FAIL single_count: got %0d words p1=%0d expected 4 0",
               got_w.size(), p1);
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL single_word[%0d]: got %h last %b expected %h last %b",
                 i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    cyc = 0;
    @(negedge clk);
    test_reset();
    test_aligned();
    test_unaligned();
    test_backpressure();
    test_flush_residual();
    test_flush_empty();
    test_restart();
    test_single_slice();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
